// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (IF, LS) and the
// single-port 256x8 synchronous memory.
//   master : requester/memory side (drives requests and memory read data)
//   slave  : arbiter side (drives grants, read-valid flags and memory controls)
interface mem_arbiter_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    // instruction fetch port (read-only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // load/store port (read/write)
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    // memory port
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single-port 256x8 synchronous memory between
// instruction fetch (read-only) and load/store (read/write). One access is
// issued per cycle; grants are combinational in the request cycle and the
// 1-cycle-latency read data is tagged back to its owner with an rvalid flag.
//
// Build option ARB_RR_EN:
//   undefined : fixed LS priority, IF forced through after STARVE_MAX
//               consecutive denied request cycles.
//   defined   : round-robin on contention (rr_last: 0=IF, 1=LS), no counter.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;

    logic          if_gnt_c;
    logic          ls_gnt_c;
    logic [AW-1:0] mem_addr_c;
    logic [AW-1:0] mem_addr_q;
    logic          if_rvalid_q;
    logic          ls_rvalid_q;

`ifdef ARB_RR_EN
    logic rr_last_q;
    logic rr_last_d;

    // Grant: single requester always wins; contention goes to whoever was not granted last.
    always_comb begin
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.ls_req) begin
                if (rr_last_q) begin
                    if_gnt_c = 1'b1;
                end else begin
                    ls_gnt_c = 1'b1;
                end
            end else begin
                if_gnt_c = bus.if_req;
                ls_gnt_c = bus.ls_req;
            end
        end
    end

    // Remember the owner of the most recent grant; hold when idle.
    always_comb begin
        rr_last_d = rr_last_q;
        if (ls_gnt_c) begin
            rr_last_d = 1'b1;
        end else if (if_gnt_c) begin
            rr_last_d = 1'b0;
        end
    end

    // Round-robin history register; reset to IF so LS wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          if_force_c;

    // Grant: LS has priority unless IF has been starved for STARVE_MAX cycles.
    always_comb begin
        if_gnt_c   = 1'b0;
        ls_gnt_c   = 1'b0;
        if_force_c = bus.if_req && (starve_cnt_q == STARVE_LIM);
        if (!rst) begin
            ls_gnt_c = bus.ls_req && !if_force_c;
            if_gnt_c = bus.if_req && (!bus.ls_req || if_force_c);
        end
    end

    // Count consecutive denied IF request cycles, saturating at the limit.
    always_comb begin
        starve_cnt_d = '0;
        if (bus.if_req && !if_gnt_c) begin
            if (starve_cnt_q == STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Address mux: granted requester drives; otherwise hold the last driven address.
    always_comb begin
        mem_addr_c = mem_addr_q;
        if (rst) begin
            mem_addr_c = '0;
        end else if (if_gnt_c) begin
            mem_addr_c = bus.if_addr;
        end else if (ls_gnt_c) begin
            mem_addr_c = bus.ls_addr;
        end
    end

    // Address hold copy and read-valid tags for the 1-cycle memory latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_c;
            if_rvalid_q <= if_gnt_c;
            ls_rvalid_q <= ls_gnt_c && !bus.ls_we;
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.ls_gnt    = ls_gnt_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_we    = ls_gnt_c && bus.ls_we;
    assign bus.mem_wdata = rst ? DW'(0) : bus.ls_wdata;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    // Read data is shared; ownership is carried by the rvalid flags alone.
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    // Grants are mutually exclusive and only follow a request.
    a_onehot_gnt: assert property (@(posedge clk) disable iff (rst) !(if_gnt_c && ls_gnt_c));
    a_if_gnt_req: assert property (@(posedge clk) disable iff (rst) if_gnt_c |-> bus.if_req);
    a_ls_gnt_req: assert property (@(posedge clk) disable iff (rst) ls_gnt_c |-> bus.ls_req);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, a reference model
// checked every cycle on the falling edge, and directed literal expectations.
module tb_mem_arbiter;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem       [256];
    logic [7:0] model_mem [256];

    // Single-port synchronous memory, 1-cycle registered read.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int         denied;
    logic       last_ls;
    logic [7:0] last_addr;
    logic       pend_if;
    logic       pend_ls;
    logic [7:0] pend_data;

    // Model compare: evaluated mid-cycle, then advanced to the next edge.
    always @(negedge clk) begin
        logic       eg_if;
        logic       eg_ls;
        logic [7:0] ea;
        if (rst) begin
            chk("rst_if_gnt", 16'(bus.if_gnt), 16'h0);
            chk("rst_ls_gnt", 16'(bus.ls_gnt), 16'h0);
            chk("rst_mem_we", 16'(bus.mem_we), 16'h0);
            chk("rst_mem_addr", 16'(bus.mem_addr), 16'h0);
            chk("rst_mem_wdata", 16'(bus.mem_wdata), 16'h0);
            chk("rst_if_rvalid", 16'(bus.if_rvalid), 16'h0);
            chk("rst_ls_rvalid", 16'(bus.ls_rvalid), 16'h0);
            denied = 0; last_ls = 1'b0; last_addr = 8'h00;
            pend_if = 1'b0; pend_ls = 1'b0; pend_data = 8'h00;
        end else begin
            eg_if = 1'b0;
            eg_ls = 1'b0;
`ifdef ARB_RR_EN
            if (bus.if_req && bus.ls_req) begin
                if (last_ls) eg_if = 1'b1;
                else         eg_ls = 1'b1;
            end else begin
                eg_if = bus.if_req;
                eg_ls = bus.ls_req;
            end
`else
            if (bus.if_req && bus.ls_req) begin
                if (denied >= int'(STARVE_MAX)) eg_if = 1'b1;
                else                            eg_ls = 1'b1;
            end else begin
                eg_if = bus.if_req;
                eg_ls = bus.ls_req;
            end
`endif
            ea = eg_if ? bus.if_addr : (eg_ls ? bus.ls_addr : last_addr);
            chk("m_if_gnt", 16'(bus.if_gnt), 16'(eg_if));
            chk("m_ls_gnt", 16'(bus.ls_gnt), 16'(eg_ls));
            chk("m_mem_addr", 16'(bus.mem_addr), 16'(ea));
            chk("m_mem_we", 16'(bus.mem_we), 16'(eg_ls && bus.ls_we));
            chk("m_mem_wdata", 16'(bus.mem_wdata), 16'(bus.ls_wdata));
            chk("m_if_rvalid", 16'(bus.if_rvalid), 16'(pend_if));
            chk("m_ls_rvalid", 16'(bus.ls_rvalid), 16'(pend_ls));
            if (pend_if) chk("m_if_rdata", 16'(bus.if_rdata), 16'(pend_data));
            if (pend_ls) chk("m_ls_rdata", 16'(bus.ls_rdata), 16'(pend_data));
            if (eg_ls && bus.ls_we) model_mem[ea] = bus.ls_wdata;
            pend_if   = eg_if;
            pend_ls   = eg_ls && !bus.ls_we;
            pend_data = model_mem[ea];
            if (bus.if_req && !eg_if)
                denied = (denied < int'(STARVE_MAX)) ? denied + 1 : denied;
            else
                denied = 0;
            if (eg_if)      last_ls = 1'b0;
            else if (eg_ls) last_ls = 1'b1;
            last_addr = ea;
        end
    end

    task automatic set_in(input logic ir, input logic [7:0] ia, input logic lr,
                          input logic lw, input logic [7:0] la, input logic [7:0] ld);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.ls_req   = lr;
        bus.ls_we    = lw;
        bus.ls_addr  = la;
        bus.ls_wdata = ld;
    endtask

    // Apply one cycle of inputs just after the edge, return mid-cycle.
    task automatic drive(input logic ir, input logic [7:0] ia, input logic lr,
                         input logic lw, input logic [7:0] la, input logic [7:0] ld);
        @(posedge clk);
        #1;
        set_in(ir, ia, lr, lw, la, ld);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [8];
        logic       exp_ls;
        t1 = '{8'h50, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 8; i++) mem[i] = t1[i];
        mem[8'hE0] = 8'h0D;
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        bus.mem_rdata = 8'h00;

        rst = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // IF-only streaming reads
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 8'h00);
            chk("t1_if_gnt", 16'(bus.if_gnt), 16'h1);
            chk("t1_ls_rvalid", 16'(bus.ls_rvalid), 16'h0);
            if (i > 0) begin
                chk("t1_if_rvalid", 16'(bus.if_rvalid), 16'h1);
                chk("t1_if_rdata", 16'(bus.if_rdata), 16'(t1[i-1]));
            end
        end
        idle();
        chk("t1_last_rvalid", 16'(bus.if_rvalid), 16'h1);
        chk("t1_last_rdata", 16'(bus.if_rdata), 16'h07);
        chk("t1_hold_addr", 16'(bus.mem_addr), 16'h07);

        // Contention: LS read wins
        drive(1'b1, 8'h10, 1'b1, 1'b0, 8'hE0, 8'h00);
        chk("t2_ls_gnt", 16'(bus.ls_gnt), 16'h1);
        chk("t2_if_gnt", 16'(bus.if_gnt), 16'h0);
        idle();
        chk("t2_ls_rvalid", 16'(bus.ls_rvalid), 16'h1);
        chk("t2_ls_rdata", 16'(bus.ls_rdata), 16'h0D);
        chk("t2_if_rvalid", 16'(bus.if_rvalid), 16'h0);

        // LS write then read-after-write
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hE0, 8'h15);
        chk("t3_mem_we", 16'(bus.mem_we), 16'h1);
        chk("t3_mem_wdata", 16'(bus.mem_wdata), 16'h15);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'hE0, 8'h00);
        chk("t3_we_drop", 16'(bus.mem_we), 16'h0);
        chk("t3_no_rvalid", 16'(bus.ls_rvalid), 16'h0);
        idle();
        chk("t3_raw_rvalid", 16'(bus.ls_rvalid), 16'h1);
        chk("t3_raw_rdata", 16'(bus.ls_rdata), 16'h15);

        // Reset in the middle of an IF read
        drive(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("t5_if_gnt", 16'(bus.if_gnt), 16'h1);
        #2 rst = 1'b1;
        drive(1'b1, 8'h02, 1'b1, 1'b0, 8'h03, 8'h00);
        chk("t5_rvalid_dropped", 16'(bus.if_rvalid), 16'h0);
        chk("t5_if_gnt_rst", 16'(bus.if_gnt), 16'h0);
        chk("t5_ls_gnt_rst", 16'(bus.ls_gnt), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("t5_if_gnt_release", 16'(bus.if_gnt), 16'h1);
        chk("t5_mem_addr", 16'(bus.mem_addr), 16'h05);
        idle();
        chk("t5_rdata", 16'(bus.if_rdata), 16'h05);

        // Both held requesting from reset: starvation release or round-robin
        #2 rst = 1'b1;
        set_in(1'b1, 8'h03, 1'b1, 1'b0, 8'hE0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) drive(1'b1, 8'h03, 1'b1, 1'b0, 8'hE0, 8'h00);
`ifdef ARB_RR_EN
            exp_ls = (k % 2) == 0;
`else
            exp_ls = (k != 4) && (k != 9);
`endif
            chk("t4_ls_gnt", 16'(bus.ls_gnt), 16'(exp_ls));
            chk("t4_if_gnt", 16'(bus.if_gnt), 16'(!exp_ls));
        end
        idle();

        // Mixed directed traffic covered by the model
        for (int i = 0; i < 40; i++) begin
            logic [7:0] v;
            v = 8'(i);
            drive(v[0] ^ v[3], 8'(i * 5), v[1] | (v[4] & v[0]), v[2], 8'(8'hC0 + 8'(i % 6)), 8'(i * 13));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
